spi_reg_sched: RTL

//  Sequences the shared SPI link to the USB host controller chip (SS/SCLK/MOSI/MISO, U_RES, INT).

---
 rtl/spi_reg_sched_pkg.sv | 27 ++
 rtl/spi_reg_sched_if.sv | 22 ++
 rtl/spi_reg_sched_shift16.sv | 69 ++++++
 rtl/spi_reg_sched.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/spi_reg_sched_pkg.sv
// Shared types and helpers for the USB host chip SPI sequencer.
package spi_reg_sched_pkg;

    localparam int IRQ_REG_DEF = 25;

    typedef enum logic [1:0] {
        RES_HOLD,
        IDLE,
        XFER,
        GAP
    } state_t;

    typedef enum logic {
        GNT_HOST,
        GNT_IRQ
    } grant_t;

    typedef struct packed {
        grant_t grant;
        logic   wr;
    } xact_t;

    function automatic logic [7:0] cmd_byte(input logic [4:0] addr, input logic wr);
        return {addr, 1'b0, wr, 1'b0};
    endfunction

endpackage

// File: rtl/spi_reg_sched_if.sv
// Host register access handshake between the PCMCIA I/O decode and the SPI sequencer.
interface spi_reg_sched_if;

    logic       host_req;
    logic       host_wr;
    logic [4:0] host_reg;
    logic [7:0] host_wdata;
    logic       host_ack;
    logic [7:0] host_rdata;
    logic       host_busy;

    modport master (
        output host_req, host_wr, host_reg, host_wdata,
        input  host_ack, host_rdata, host_busy
    );

    modport slave (
        input  host_req, host_wr, host_reg, host_wdata,
        output host_ack, host_rdata, host_busy
    );

endinterface

// File: rtl/spi_reg_sched_shift16.sv
// 16-bit SPI mode-0 shifter: one command byte out, one data byte in/out, MSB first.
module spi_shift16 #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] tx,
    input  logic        miso,
    output logic        ss,
    output logic        sclk,
    output logic        mosi,
    output logic        done,
    output logic [7:0]  rx
);
    localparam int DW = $clog2(CLK_DIV + 1);

    logic          active;
    logic [DW-1:0] dcnt;
    logic [5:0]    ph;
    logic [15:0]   tx_sh;
    logic          tick;

    // 33 half-periods: a low lead-in, then 16 high/low SCLK pairs
    assign tick = active && (dcnt == DW'(CLK_DIV - 1));
    assign done = tick && (ph == 6'd32);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            dcnt   <= '0;
            ph     <= '0;
            tx_sh  <= '0;
            rx     <= '0;
            ss     <= 1'b1;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
        end else if (active) begin
            if (!tick) begin
                dcnt <= dcnt + 1'b1;
            end else begin
                dcnt <= '0;
                ph   <= ph + 6'd1;
                if (ph == 6'd32) begin
                    active <= 1'b0;
                    ph     <= '0;
                    ss     <= 1'b1;
                    mosi   <= 1'b0;
                end else if (!ph[0]) begin
                    sclk <= 1'b1;
                    rx   <= {rx[6:0], miso};
                end else begin
                    sclk  <= 1'b0;
                    mosi  <= tx_sh[15];
                    tx_sh <= {tx_sh[14:0], 1'b0};
                end
            end
        end else if (start) begin
            active <= 1'b1;
            dcnt   <= '0;
            ph     <= '0;
            ss     <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= tx[15];
            tx_sh  <= {tx[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_reg_sched.sv
// SPI link sequencer for the USB host chip: chip reset hold,
// host/IRQ-poller arbitration and transaction FSM.
module spi_reg_sched
    import spi_reg_sched_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int RES_CYCLES  = 1040,
    parameter int IRQ_REG     = IRQ_REG_DEF,
    parameter int ACK_IRQ     = 1,
    parameter int IRQ_HOLDOFF = 64
) (
    input  logic           CLK,
    input  logic           RESET_N,
    spi_reg_sched_if.slave host,
    input  logic           int_n,
    output logic [7:0]     irq_status,
    output logic           irq_valid,
    output logic           SS,
    output logic           SCLK,
    output logic           MOSI,
    input  logic           MISO,
    output logic           U_RES
);
    localparam int RES_W = $clog2(RES_CYCLES + 2);
    localparam int GAP_W = $clog2(2 * CLK_DIV + 1);
    localparam int HO_W  = $clog2(IRQ_HOLDOFF + 2);

    state_t           state;
    state_t           state_nx;
    logic [RES_W-1:0] res_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [HO_W-1:0]  holdoff;
    logic [1:0]       int_sync;
    logic             ack_pend;
    logic [7:0]       ack_val;
    grant_t           last_grant;
    xact_t            cur;

    logic             irq_req;
    logic             start;
    logic             pick_irq;
    logic             irq_wr;
    logic [15:0]      tx;
    logic             sh_done;
    logic [7:0]       sh_rx;

    spi_shift16 #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk   (CLK),
        .rst_n (RESET_N),
        .start (start),
        .tx    (tx),
        .miso  (MISO),
        .ss    (SS),
        .sclk  (SCLK),
        .mosi  (MOSI),
        .done  (sh_done),
        .rx    (sh_rx)
    );

    assign irq_req = !int_sync[1] && (holdoff == '0) && !ack_pend;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= RES_HOLD;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        pick_irq = 1'b0;
        irq_wr   = 1'b0;
        tx       = 16'h0000;
        unique case (state)
            RES_HOLD: begin
                if (res_cnt == RES_W'(RES_CYCLES - 1)) state_nx = IDLE;
            end
            IDLE: begin
                // a pending HIRQ clear always beats a fresh request
                if (ack_pend) begin
                    start    = 1'b1;
                    pick_irq = 1'b1;
                    irq_wr   = 1'b1;
                end else if (irq_req && host.host_req) begin
                    start    = 1'b1;
                    pick_irq = (last_grant == GNT_HOST);
                end else if (irq_req) begin
                    start    = 1'b1;
                    pick_irq = 1'b1;
                end else if (host.host_req) begin
                    start    = 1'b1;
                end
                if (start) state_nx = XFER;
            end
            XFER: begin
                if (sh_done) state_nx = GAP;
            end
            GAP: begin
                if (gap_cnt == GAP_W'(2 * CLK_DIV - 2)) state_nx = IDLE;
            end
            default: state_nx = RES_HOLD;
        endcase
        if (pick_irq) begin
            tx = {cmd_byte(5'(IRQ_REG), irq_wr), irq_wr ? ack_val : 8'h00};
        end else begin
            tx = {cmd_byte(host.host_reg, host.host_wr),
                  host.host_wr ? host.host_wdata : 8'h00};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            res_cnt         <= '0;
            U_RES           <= 1'b0;
            gap_cnt         <= '0;
            holdoff         <= '0;
            int_sync        <= 2'b11;
            ack_pend        <= 1'b0;
            ack_val         <= '0;
            last_grant      <= GNT_HOST;
            cur             <= '{grant: GNT_HOST, wr: 1'b0};
            host.host_ack   <= 1'b0;
            host.host_rdata <= '0;
            host.host_busy  <= 1'b0;
            irq_status      <= '0;
            irq_valid       <= 1'b0;
        end else begin
            host.host_ack <= 1'b0;
            irq_valid     <= 1'b0;
            int_sync      <= {int_sync[0], int_n};

            if (state == RES_HOLD) begin
                res_cnt <= res_cnt + 1'b1;
                if (state_nx == IDLE) U_RES <= 1'b1;
            end

            if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
            else              gap_cnt <= '0;

            if (holdoff != '0) holdoff <= holdoff - 1'b1;

            if (start) begin
                last_grant <= pick_irq ? GNT_IRQ : GNT_HOST;
                cur.grant  <= pick_irq ? GNT_IRQ : GNT_HOST;
                cur.wr     <= pick_irq ? irq_wr : host.host_wr;
                if (irq_wr) ack_pend <= 1'b0;
            end

            if (sh_done) begin
                if (cur.grant == GNT_HOST) begin
                    host.host_ack <= 1'b1;
                    if (!cur.wr) host.host_rdata <= sh_rx;
                end else if (cur.wr) begin
                    holdoff <= HO_W'(IRQ_HOLDOFF);
                end else begin
                    irq_status <= sh_rx;
                    irq_valid  <= 1'b1;
                    if (ACK_IRQ != 0 && sh_rx != 8'h00) begin
                        ack_pend <= 1'b1;
                        ack_val  <= sh_rx;
                    end else begin
                        holdoff <= HO_W'(IRQ_HOLDOFF);
                    end
                end
            end

            // busy tracks the request level, but sticks while the host owns the link
            if (sh_done && cur.grant == GNT_HOST) begin
                host.host_busy <= 1'b0;
            end else if (state == XFER && cur.grant == GNT_HOST) begin
                host.host_busy <= 1'b1;
            end else begin
                host.host_busy <= host.host_req;
            end
        end
    end

endmodule
